// File: rtl/buf_tag_ctrl_pkg.sv
// Shared types and sizes for the buffer tag controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package buf_tag_ctrl_pkg;

    localparam int NUM_BUF = 4;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WAIT_REPL,
        RESP
    } state_t;

endpackage

// File: rtl/buf_tag_match.sv
// 4-way tag compare plus lowest-index free-entry priority encoder.
// Latency: purely combinational.
// Backpressure: none; it is evaluated every cycle.
module buf_tag_match
    import buf_tag_ctrl_pkg::*;
(
    input  logic [NUM_BUF-1:0][TAG_W-1:0] tags,
    input  logic [NUM_BUF-1:0]            valid,
    input  logic [TAG_W-1:0]              tag,
    output logic                          hit,
    output logic [IDX_W-1:0]              hit_idx,
    output logic                          has_free,
    output logic [IDX_W-1:0]              free_idx
);

    // Scan from the top index down so the lowest matching/free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/buf_tag_ctrl.sv
// Four-entry tag directory: looks up a tag, installs it on a miss, asks the LFU stage for a victim when full.
// Latency: response 2 cycles after accept (hit/fill), 3 cycles when a replacement is needed.
// Backpressure: response held in RESP until resp_ready; no new request accepted meanwhile.
module buf_tag_ctrl
    import buf_tag_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [7:0]       req_tag,
    output logic             req_ready,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [1:0]       resp_buf,
    output logic             ref_buf_vld,
    output logic [1:0]       ref_buf_numbr,
    output logic             new_buf_req,
    input  logic [1:0]       buf_num_replc
);

    state_t                          state;
    state_t                          next_state;
    logic [NUM_BUF-1:0][TAG_W-1:0]   tags;
    logic [NUM_BUF-1:0]              valid;
    logic [TAG_W-1:0]                cap_tag;
    logic                            hit;
    logic [IDX_W-1:0]                hit_idx;
    logic                            has_free;
    logic [IDX_W-1:0]                free_idx;
    logic                            accept;

    assign accept = (state == IDLE) && req_valid && !flush;

    buf_tag_match u_match (
        .tags     (tags),
        .valid    (valid),
        .tag      (cap_tag),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .has_free (has_free),
        .free_idx (free_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-state strobes; strobes only come out of LOOKUP so they can never overlap.
    always_comb begin
        next_state    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        ref_buf_vld   = 1'b0;
        ref_buf_numbr = '0;
        new_buf_req   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (accept) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ref_buf_vld   = 1'b1;
                    ref_buf_numbr = hit_idx;
                    next_state    = RESP;
                end else if (has_free) begin
                    ref_buf_vld   = 1'b1;
                    ref_buf_numbr = free_idx;
                    next_state    = RESP;
                end else begin
                    new_buf_req = 1'b1;
                    next_state  = WAIT_REPL;
                end
            end
            WAIT_REPL: begin
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Valid bits and response fields; response registers only change in LOOKUP/WAIT_REPL so they stay stable in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            resp_hit <= 1'b0;
            resp_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_hit <= 1'b1;
                        resp_buf <= hit_idx;
                    end else if (has_free) begin
                        valid[free_idx] <= 1'b1;
                        resp_hit        <= 1'b0;
                        resp_buf        <= free_idx;
                    end
                end
                WAIT_REPL: begin
                    resp_hit <= 1'b0;
                    resp_buf <= buf_num_replc;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag storage and captured request tag; contents are qualified by valid bits so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_tag <= req_tag;
        end
        if ((state == LOOKUP) && !hit && has_free) begin
            tags[free_idx] <= cap_tag;
        end
        if (state == WAIT_REPL) begin
            tags[buf_num_replc] <= cap_tag;
        end
    end

endmodule
